// File: rtl/ring_ctrl_pkg.sv
// rtl/ring_ctrl_pkg.sv - shared op codes, FSM states and reset token for the ring controller
package ring_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_LOAD   = 2'b00,
      OP_ROTATE = 2'b01,
      OP_SWAP   = 2'b10,
      OP_CLEAR  = 2'b11
   } op_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ROT  = 1'b1
   } state_t;

   // Value placed in entry 0 at reset; every other entry resets to zero.
   localparam int RESET_TOKEN = 1;

endpackage

// File: rtl/ring_regfile.sv
// rtl/ring_regfile.sv - DEPTH x WIDTH circular register storage with load/rotate/swap/clear
module ring_regfile
   import ring_ctrl_pkg::*;
#(
   parameter int DEPTH = 5,
   parameter int WIDTH = 2,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic                   clock,
   input  logic                   rst,
   input  logic                   load_en,
   input  logic                   rot_en,
   input  logic                   swap_en,
   input  logic                   clr_en,
   input  logic [IDX_W-1:0]       idx_a,
   input  logic [IDX_W-1:0]       idx_b,
   input  logic [WIDTH-1:0]       data,
   output logic [DEPTH*WIDTH-1:0] ring_q
);

   logic [WIDTH-1:0] entries [DEPTH];

   // Storage update; controls are one-hot from the controller, indices already range-checked.
   always_ff @(posedge clock) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= (i == 0) ? WIDTH'(RESET_TOKEN) : '0;
         end
      end else if (clr_en) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else if (rot_en) begin
         entries[0] <= entries[DEPTH-1];
         for (int i = 1; i < DEPTH; i++) begin
            entries[i] <= entries[i-1];
         end
      end else if (load_en) begin
         entries[idx_a] <= data;
      end else if (swap_en) begin
         entries[idx_a] <= entries[idx_b];
         entries[idx_b] <= entries[idx_a];
      end
   end

   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : g_flat
         assign ring_q[g*WIDTH +: WIDTH] = entries[g];
      end
   endgenerate

endmodule

// File: rtl/ring_rotate_ctrl.sv
// rtl/ring_rotate_ctrl.sv - command FSM sequencing load/rotate/swap/clear on a register ring
module ring_rotate_ctrl
   import ring_ctrl_pkg::*;
#(
   parameter int DEPTH = 5,
   parameter int WIDTH = 2,
   parameter int CNT_W = 4,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic                   clock,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [IDX_W-1:0]       cmd_idx_a,
   input  logic [IDX_W-1:0]       cmd_idx_b,
   input  logic [CNT_W-1:0]       cmd_count,
   input  logic [WIDTH-1:0]       cmd_data,
   output logic [DEPTH*WIDTH-1:0] ring_q,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             load_en, rot_en, swap_en, clr_en;
   logic             accept;
   logic             a_ok, b_ok;

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q == ST_ROT);
   assign done      = done_q;
   assign err       = err_q;
   assign accept    = cmd_valid && cmd_ready;

   // Index range checks are done at 32 bits so DEPTH equal to 2**IDX_W still works.
   assign a_ok = {{(32-IDX_W){1'b0}}, cmd_idx_a} < 32'(DEPTH);
   assign b_ok = {{(32-IDX_W){1'b0}}, cmd_idx_b} < 32'(DEPTH);

   // State, step counter and completion flags; reset aborts any rotate without a done.
   always_ff @(posedge clock) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   // Next-state decode and one-hot storage controls.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      load_en     = 1'b0;
      rot_en      = 1'b0;
      swap_en     = 1'b0;
      clr_en      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (op_t'(cmd_op))
                  OP_LOAD: begin
                     done_d = 1'b1;
                     if (a_ok) load_en = 1'b1;
                     else      err_d   = 1'b1;
                  end
                  OP_SWAP: begin
                     done_d = 1'b1;
                     if (a_ok && b_ok) swap_en = (cmd_idx_a != cmd_idx_b);
                     else              err_d   = 1'b1;
                  end
                  OP_CLEAR: begin
                     done_d = 1'b1;
                     clr_en = 1'b1;
                  end
                  OP_ROTATE: begin
                     if (cmd_count == '0) begin
                        done_d = 1'b1;
                     end else begin
                        state_d     = ST_ROT;
                        remaining_d = cmd_count;
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_ROT: begin
            rot_en      = 1'b1;
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   ring_regfile #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_regfile (
      .clock   (clock),
      .rst     (rst),
      .load_en (load_en),
      .rot_en  (rot_en),
      .swap_en (swap_en),
      .clr_en  (clr_en),
      .idx_a   (cmd_idx_a),
      .idx_b   (cmd_idx_b),
      .data    (cmd_data),
      .ring_q  (ring_q)
   );

endmodule

// File: tb/tb_ring_rotate_ctrl.sv
// tb/tb_ring_rotate_ctrl.sv - directed self-checking bench for ring_rotate_ctrl
module tb_ring_rotate_ctrl;

   logic       clock = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [2:0] cmd_idx_a = '0;
   logic [2:0] cmd_idx_b = '0;
   logic [3:0] cmd_count = '0;
   logic [1:0] cmd_data = '0;
   logic [9:0] ring_q;
   logic       busy, done, err;

   int n_checks = 0;
   int n_fail   = 0;

   ring_rotate_ctrl dut (
      .clock     (clock),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_idx_a (cmd_idx_a),
      .cmd_idx_b (cmd_idx_b),
      .cmd_count (cmd_count),
      .cmd_data  (cmd_data),
      .ring_q    (ring_q),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                        input logic [3:0] cnt, input logic [1:0] dat);
      cmd_op    = op;
      cmd_idx_a = a;
      cmd_idx_b = b;
      cmd_count = cnt;
      cmd_data  = dat;
      cmd_valid = 1'b1;
      step();
   endtask

   task automatic do_reset();
      cmd_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      // reset and idle
      step();
      step();
      rst = 1'b0;
      repeat (3) step();
      check_eq("rst_ring", 32'(ring_q), 32'h001);
      check_eq("rst_ready", 32'(cmd_ready), 1);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(done), 0);
      check_eq("rst_err", 32'(err), 0);

      // rotate by 3
      issue(2'b01, 3'd0, 3'd0, 4'd3, 2'b00);
      cmd_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check_eq($sformatf("rot3_busy%0d", k), 32'(busy), 1);
         check_eq($sformatf("rot3_ready%0d", k), 32'(cmd_ready), 0);
         check_eq($sformatf("rot3_nodone%0d", k), 32'(done), 0);
         step();
      end
      check_eq("rot3_busy_end", 32'(busy), 0);
      check_eq("rot3_done", 32'(done), 1);
      check_eq("rot3_ring", 32'(ring_q), 32'h040);
      step();
      check_eq("rot3_done_clr", 32'(done), 0);

      // back-to-back load then swap
      do_reset();
      issue(2'b00, 3'd4, 3'd0, 4'd0, 2'b11);
      check_eq("load_ring", 32'(ring_q), 32'h301);
      check_eq("load_done", 32'(done), 1);
      issue(2'b10, 3'd0, 3'd4, 4'd0, 2'b00);
      check_eq("swap_ring", 32'(ring_q), 32'h103);
      check_eq("swap_done", 32'(done), 1);
      check_eq("swap_err", 32'(err), 0);
      cmd_valid = 1'b0;
      step();
      check_eq("swap_done_clr", 32'(done), 0);

      // illegal indices
      do_reset();
      issue(2'b00, 3'd6, 3'd0, 4'd0, 2'b10);
      check_eq("bad_load_ring", 32'(ring_q), 32'h001);
      check_eq("bad_load_done", 32'(done), 1);
      check_eq("bad_load_err", 32'(err), 1);
      issue(2'b10, 3'd2, 3'd7, 4'd0, 2'b00);
      check_eq("bad_swap_ring", 32'(ring_q), 32'h001);
      check_eq("bad_swap_done", 32'(done), 1);
      check_eq("bad_swap_err", 32'(err), 1);
      cmd_valid = 1'b0;
      step();
      check_eq("bad_err_clr", 32'(err), 0);

      // rotate 7 with a load held valid while busy, then clear
      do_reset();
      issue(2'b01, 3'd0, 3'd0, 4'd7, 2'b00);
      cmd_op    = 2'b00;
      cmd_idx_a = 3'd0;
      cmd_data  = 2'b11;
      cmd_valid = 1'b1;
      for (int k = 0; k < 7; k++) begin
         check_eq($sformatf("rot7_busy%0d", k), 32'(busy), 1);
         step();
      end
      check_eq("rot7_busy_end", 32'(busy), 0);
      check_eq("rot7_done", 32'(done), 1);
      check_eq("rot7_ring", 32'(ring_q), 32'h010);
      issue(2'b11, 3'd0, 3'd0, 4'd0, 2'b00);
      check_eq("clr_ring", 32'(ring_q), 32'h000);
      check_eq("clr_done", 32'(done), 1);
      check_eq("clr_err", 32'(err), 0);
      cmd_valid = 1'b0;

      // reset during a rotate, then zero-count rotate
      do_reset();
      issue(2'b01, 3'd0, 3'd0, 4'd5, 2'b00);
      cmd_valid = 1'b0;
      check_eq("abort_busy", 32'(busy), 1);
      step();
      check_eq("abort_ring_mid", 32'(ring_q), 32'h004);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("abort_ring", 32'(ring_q), 32'h001);
      check_eq("abort_busy_clr", 32'(busy), 0);
      check_eq("abort_ready", 32'(cmd_ready), 1);
      for (int k = 0; k < 5; k++) begin
         check_eq($sformatf("abort_nodone%0d", k), 32'(done), 0);
         step();
      end
      issue(2'b01, 3'd0, 3'd0, 4'd0, 2'b00);
      cmd_valid = 1'b0;
      check_eq("rot0_done", 32'(done), 1);
      check_eq("rot0_busy", 32'(busy), 0);
      check_eq("rot0_err", 32'(err), 0);
      check_eq("rot0_ring", 32'(ring_q), 32'h001);
      step();
      check_eq("rot0_done_clr", 32'(done), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ring_rotate_ctrl.md
Name: ring_rotate_ctrl

Overview:
Command-driven controller for a DEPTH-entry circular register ring. Each ring entry is WIDTH bits wide. It sequences four operations on the ring: load one entry, rotate by N steps, swap two entries, and clear. A testbench or upstream sequencer issues commands over a valid/ready handshake. The ring contents are exported flat every cycle.

Parameters:
DEPTH, 5, number of ring entries (must be >= 2)
WIDTH, 2, bits per entry
CNT_W, 4, width of rotate step count
IDX_W, $clog2(DEPTH), width of entry index (derived localparam)

Ports:
clock  in  1  sole clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command this cycle
cmd_op  in  2  00 LOAD, 01 ROTATE, 10 SWAP, 11 CLEAR
cmd_idx_a  in  IDX_W  target entry (LOAD), first entry (SWAP)
cmd_idx_b  in  IDX_W  second entry (SWAP)
cmd_count  in  CNT_W  rotate steps (ROTATE)
cmd_data  in  WIDTH  load value (LOAD)
ring_q  out  DEPTH*WIDTH  entry i at [i*WIDTH +: WIDTH], registered
busy  out  1  high while a multi-cycle ROTATE is in progress
done  out  1  one-cycle pulse after each command completes
err  out  1  one-cycle pulse coincident with done for an illegal index

Behaviour:
- Reset (rst=1 at posedge):
  - entry 0 = 1 (one-hot token); all other entries = 0.
  - state=IDLE, remaining=0, done=0, err=0.
- Reset wins over every other event, including mid-ROTATE.
- Outputs:
  - cmd_ready = (state==IDLE), combinational from state.
  - busy = (state==ROT).
- A command is accepted at a posedge where cmd_valid && cmd_ready. With cmd_ready low, inputs are ignored. There is no buffering.
- States: IDLE, ROT.
- LOAD:
  - At the accept edge, entry[idx_a] <= cmd_data. done=1 in the following cycle.
  - idx_a >= DEPTH: no change; done=1 and err=1.
- SWAP:
  - At the accept edge, entry[a] <= entry[b] and entry[b] <= entry[a], both from pre-edge values.
  - a==b: no change, done only.
  - Either index >= DEPTH: no change, done+err.
- CLEAR: all entries <= 0 at the accept edge; done next cycle.
- ROTATE with count==0: no change, done next cycle, stays IDLE.
- ROTATE with count N>0:
  - Accept edge: no data movement; state<=ROT, remaining<=N.
  - Each ROT edge: entry[i] <= entry[i-1] for i>0, entry[0] <= entry[DEPTH-1]; remaining decrements.
  - On the edge where remaining==1: state<=IDLE, done=1 in the next cycle.
  - busy is high for exactly N cycles. done appears N+1 edges after accept.
  - N is not reduced mod DEPTH.
- Back-to-back single-cycle commands are accepted every cycle. done pulses each cycle.
- The first command after a ROTATE can be accepted in the same cycle done is high.
- err is never asserted for ROTATE or CLEAR. cmd_idx_* are ignored for those ops.
- Reset mid-ROTATE: ring returns to reset pattern, busy=0 next cycle, no done for the aborted command.

Decomposition:
- Package ring_ctrl_pkg:
  - op codes OP_LOAD/OP_ROTATE/OP_SWAP/OP_CLEAR
  - state encoding ST_IDLE/ST_ROT
  - reset token constant
- Sub-module ring_regfile (DEPTH, WIDTH): storage only, with one-hot controls load_en/rot_en/swap_en/clr_en plus indices and data. It owns the reset pattern.
- ring_rotate_ctrl holds the FSM, the step counter, index checks, and done/err generation.

Test Plan:
- Reset, then idle 3 cycles -> ring_q=10'b00_00_00_00_01, cmd_ready=1, busy=0, done=0.
- ROTATE count=3 after reset -> busy high 3 cycles, ring_q=10'b00_01_00_00_00, done pulse 4 edges after accept, cmd_ready low while busy.
- LOAD idx=4 data=2'b11, then SWAP a=0 b=4 back-to-back -> after LOAD ring_q[9:8]=11; after SWAP ring_q=10'b01_00_00_00_11; two consecutive done pulses.
- LOAD idx=6 data=2'b10 and SWAP a=2 b=7 -> ring unchanged, done=1 and err=1 together for each.
- ROTATE count=7 held valid during busy, then CLEAR -> token at entry 2 after 7 cycles, commands during busy ignored, then ring_q=0.
- ROTATE count=5, rst=1 on 2nd ROT cycle -> next cycle ring_q=10'b00_00_00_00_01, busy=0, no done pulse; ROTATE count=0 afterwards -> done only, ring unchanged.
